// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and store-lane helpers for the MEM pipeline stage.
// Memory size codes, FSM state encoding, byte-enable/data replication functions.
package mem_access_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Size code 2'b11 falls into the word branch on purpose.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: return 4'b0001 << lane;
            MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            MEM_BYTE: return {4{wd[7:0]}};
            MEM_HALF: return {2{wd[15:0]}};
            default:  return wd;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == MEM_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata;
    logic             ack;
    logic [WIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_load_align.sv
// Load data formatter: selects the addressed byte/half of the read word and
// zero- or sign-extends it to the full datapath width.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] readdata
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[addr];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            MEM_BYTE: readdata = {{24{is_signed & byte_sel[7]}}, byte_sel};
            MEM_HALF: readdata = {{16{is_signed & half_sel[15]}}, half_sel};
            default:  readdata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle loads/stores over a req/ack bus, upstream stall, load formatting.
// Optional build macro MEM_ALIGN_CHECK_EN adds misaligned-access trapping and the misalign_exc output.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH       = DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_em,
    input  logic             memread_em,
    input  logic             memwrite_em,
    input  logic [1:0]       memsize_em,
    input  logic             memsigned_em,
    input  logic             regwrite_em,
    input  logic             memtoreg_em,
    input  logic [WIDTH-1:0] aluout_em,
    input  logic [WIDTH-1:0] writedata_em,
    input  logic [4:0]       regaddr_em,
    mem_access_stage_if.master dmem,
    output logic             stall_mem,
    output logic             regwrite_mem,
    output logic             memtoreg_mem,
    output logic [WIDTH-1:0] aluout_mem,
    output logic [WIDTH-1:0] readdata_mem,
    output logic [4:0]       regaddr_mem,
    output logic             bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic             misalign_exc
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic             timed_out_reg, timed_out_next;
    logic             bus_err_reg, bus_err_next;
    logic             we_reg, we_next;
    logic [3:0]       be_reg, be_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0] wdata_reg, wdata_next;

    logic             is_access;
    logic             misaligned;
    logic [WIDTH-1:0] load_data;

    assign is_access = valid_em & (memread_em | memwrite_em);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(memsize_em, aluout_em[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // EX2MEM is frozen by the stall, so the live address/size still describe the held load.
    mem_load_align u_load_align (
        .rdata     (rdata_reg),
        .addr      (aluout_em[1:0]),
        .size      (memsize_em),
        .is_signed (memsigned_em),
        .readdata  (load_data)
    );

    assign dmem.req   = (state_reg == ST_REQ);
    assign dmem.we    = we_reg;
    assign dmem.be    = be_reg;
    assign dmem.addr  = addr_reg;
    assign dmem.wdata = wdata_reg;
    assign bus_err    = bus_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
            timed_out_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            timed_out_reg <= timed_out_next;
            bus_err_reg   <= bus_err_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        timed_out_next = timed_out_reg;
        bus_err_next   = 1'b0;
        we_next        = we_reg;
        be_next        = be_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;

        stall_mem      = 1'b0;
        regwrite_mem   = valid_em & regwrite_em & ~memwrite_em;
        memtoreg_mem   = memtoreg_em;
        aluout_mem     = aluout_em;
        readdata_mem   = '0;
        regaddr_mem    = regaddr_em;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_exc   = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (is_access && misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_exc = 1'b1;
`endif
                    regwrite_mem = 1'b0;
                    memtoreg_mem = 1'b0;
                end else if (is_access) begin
                    stall_mem      = 1'b1;
                    regwrite_mem   = 1'b0;
                    memtoreg_mem   = 1'b0;
                    we_next        = memwrite_em;
                    be_next        = store_be(memsize_em, aluout_em[1:0]);
                    addr_next      = {aluout_em[WIDTH-1:2], 2'b00};
                    wdata_next     = store_wdata(memsize_em, writedata_em);
                    cnt_next       = '0;
                    timed_out_next = 1'b0;
                    state_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_mem    = 1'b1;
                regwrite_mem = 1'b0;
                memtoreg_mem = 1'b0;
                cnt_next     = cnt_reg + 1'b1;
                if (dmem.ack) begin
                    rdata_next = dmem.rdata;
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    bus_err_next   = 1'b1;
                    timed_out_next = 1'b1;
                    rdata_next     = '0;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (timed_out_reg) begin
                    regwrite_mem = 1'b0;
                end
                if (memread_em) begin
                    readdata_mem = load_data;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM2WB results are queued when an op is
// driven and compared when the stage releases it; a simple memory model answers the bus.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_em, memread_em, memwrite_em, memsigned_em, regwrite_em, memtoreg_em;
    logic [1:0]  memsize_em;
    logic [31:0] aluout_em, writedata_em;
    logic [4:0]  regaddr_em;
    logic        stall_mem, regwrite_mem, memtoreg_mem, bus_err;
    logic [31:0] aluout_mem, readdata_mem;
    logic [4:0]  regaddr_mem;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_exc;
`endif

    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_em     (valid_em),
        .memread_em   (memread_em),
        .memwrite_em  (memwrite_em),
        .memsize_em   (memsize_em),
        .memsigned_em (memsigned_em),
        .regwrite_em  (regwrite_em),
        .memtoreg_em  (memtoreg_em),
        .aluout_em    (aluout_em),
        .writedata_em (writedata_em),
        .regaddr_em   (regaddr_em),
        .dmem         (bus),
        .stall_mem    (stall_mem),
        .regwrite_mem (regwrite_mem),
        .memtoreg_mem (memtoreg_mem),
        .aluout_mem   (aluout_mem),
        .readdata_mem (readdata_mem),
        .regaddr_mem  (regaddr_mem),
        .bus_err      (bus_err)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_exc (misalign_exc)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int op_id    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] aluout;
        logic [31:0] readdata;
        logic [4:0]  regaddr;
        int          req_cycles;
        logic        bus_err;
        logic        misalign;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] sh;
        if (sz == 2'b00) begin
            sh = w >> (8 * a);
            return (sg && sh[7]) ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
        end else if (sz == 2'b01) begin
            sh = a[1] ? (w >> 16) : w;
            return (sg && sh[15]) ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
        end
        return w;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) return 4'b0001 << a;
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (sz == 2'b01) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [1:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'b01 && a[0]) || (sz >= 2'b10 && a != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        valid_em = 0; memread_em = 0; memwrite_em = 0; memsize_em = 2'b10; memsigned_em = 0;
        regwrite_em = 0; memtoreg_em = 0; aluout_em = 0; writedata_em = 0; regaddr_em = 0;
    endtask

    // ack_cyc: REQ cycle (1-based) in which memory acks; 0 = never. stray: ack high outside REQ.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic rw, input logic m2r, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] ra, input int ack_cyc,
                          input logic [31:0] rdata, input logic stray);
        exp_t e, got_e;
        logic acc, mis, tmo, done;
        int   stalls, reqs, errs, mcnt;
        acc = v & (rd | wr);
        mis = acc & model_misaligned(sz, addr[1:0]);
        tmo = acc & !mis & (ack_cyc == 0);
        e.req_cycles = (acc && !mis) ? ((ack_cyc == 0) ? 16 : ack_cyc) : 0;
        e.regwrite   = v & rw & ~wr & ~tmo & ~mis;
        e.memtoreg   = mis ? 1'b0 : m2r;
        e.aluout     = addr;
        e.regaddr    = ra;
        e.readdata   = (acc && rd && !mis && !tmo) ? model_load(rdata, addr[1:0], sz, sg) : 32'h0;
        e.bus_err    = tmo;
        e.misalign   = mis;
        e.we         = wr;
        e.be         = model_be(sz, addr[1:0]);
        e.addr       = {addr[31:2], 2'b00};
        e.wdata      = model_wdata(sz, wd);
        exp_q.push_back(e);

        valid_em = v; memread_em = rd; memwrite_em = wr; memsize_em = sz; memsigned_em = sg;
        regwrite_em = rw; memtoreg_em = m2r; aluout_em = addr; writedata_em = wd; regaddr_em = ra;

        stalls = 0; reqs = 0; errs = 0; mcnt = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.req) begin
                reqs++;
                check_eq("bus_addr", bus.addr, e.addr);
                check_eq("bus_be", {28'h0, bus.be}, {28'h0, e.be});
                check_eq("bus_we", {31'h0, bus.we}, {31'h0, e.we});
                if (wr) check_eq("bus_wdata", bus.wdata, e.wdata);
                bus.ack   = (reqs == ack_cyc);
                bus.rdata = (reqs == ack_cyc) ? rdata : $urandom;
            end else begin
                bus.ack   = stray;
                bus.rdata = $urandom;
            end
            if (bus_err) errs++;
`ifdef MEM_ALIGN_CHECK_EN
            if (misalign_exc) mcnt++;
`endif
            if (stall_mem) begin
                stalls++;
            end else begin
                done  = 1;
                got_e = exp_q.pop_front();
                check_eq("regwrite_mem", {31'h0, regwrite_mem}, {31'h0, got_e.regwrite});
                check_eq("memtoreg_mem", {31'h0, memtoreg_mem}, {31'h0, got_e.memtoreg});
                check_eq("aluout_mem", aluout_mem, got_e.aluout);
                check_eq("readdata_mem", readdata_mem, got_e.readdata);
                check_eq("regaddr_mem", {27'h0, regaddr_mem}, {27'h0, got_e.regaddr});
            end
            @(posedge clk);
            #1;
        end
        bus.ack = 0;
        check_eq("op_done", {31'h0, done}, 32'h1);
        check_eq("req_cycles", reqs, e.req_cycles);
        check_eq("stall_cycles", stalls, (e.req_cycles > 0) ? e.req_cycles + 1 : 0);
        check_eq("bus_err_pulses", errs, {31'h0, e.bus_err});
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("misalign_pulses", mcnt, {31'h0, e.misalign});
`endif
        $display("op %0d: v=%b rd=%b wr=%b sz=%0d addr=%08h -> rw=%b rdata=%08h stalls=%0d reqs=%0d err=%0d",
                 op_id, v, rd, wr, sz, addr, regwrite_mem, readdata_mem, stalls, reqs, errs);
        op_id++;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          kind, ack;
        rst = 1'b1;
        idle_inputs();
        bus.ack = 0;
        bus.rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", {31'h0, bus.req}, 32'h0);
        check_eq("rst_we", {31'h0, bus.we}, 32'h0);
        check_eq("rst_be", {28'h0, bus.be}, 32'h0);
        check_eq("rst_addr", bus.addr, 32'h0);
        check_eq("rst_wdata", bus.wdata, 32'h0);
        check_eq("rst_stall", {31'h0, stall_mem}, 32'h0);
        check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //      v  rd wr sz     sg rw m2r addr          wd            ra  ack rdata         stray
        run_op(1, 1, 0, 2'b10, 0, 1, 1, 32'h0000_0100, 32'h0,        5,  3, 32'hDEAD_BEEF, 0); // lw
        run_op(1, 1, 0, 2'b00, 1, 1, 1, 32'h0000_0103, 32'h0,        6,  1, 32'h8011_2233, 0); // lb
        run_op(1, 1, 0, 2'b00, 0, 1, 1, 32'h0000_0103, 32'h0,        7,  2, 32'h8011_2233, 0); // lbu
        run_op(1, 0, 1, 2'b01, 0, 1, 0, 32'h0000_0102, 32'h0000_ABCD, 8, 1, 32'h0,         0); // sh
        run_op(1, 0, 0, 2'b10, 0, 1, 0, 32'h1234_5678, 32'h0,        9,  0, 32'h0,         1); // add
        run_op(1, 1, 0, 2'b10, 0, 1, 1, 32'h0000_0200, 32'h0,       10,  0, 32'h0,         0); // lw timeout
        run_op(1, 1, 0, 2'b01, 1, 1, 1, 32'h0000_0102, 32'h0,       11,  2, 32'h8001_7FFF, 0); // lh
        run_op(1, 1, 0, 2'b01, 0, 1, 1, 32'h0000_0100, 32'h0,       12,  1, 32'h8001_7FFF, 0); // lhu
        run_op(1, 0, 1, 2'b00, 0, 0, 0, 32'h0000_0101, 32'h0000_005A, 0, 1, 32'h0,         1); // sb
        run_op(1, 0, 1, 2'b11, 0, 0, 0, 32'h0000_0300, 32'hCAFE_F00D, 0, 4, 32'h0,         0); // sw size 11
        run_op(0, 1, 0, 2'b10, 0, 1, 1, 32'h0000_0400, 32'h0,       13,  1, 32'h0,         0); // bubble
        run_op(1, 1, 0, 2'b10, 0, 1, 1, 32'h0000_0102, 32'h0,       14,  1, 32'h0102_0304, 0); // lw 0x102
        run_op(1, 1, 0, 2'b01, 1, 1, 1, 32'h0000_0107, 32'h0,       15,  2, 32'hF00F_8123, 0); // lh odd

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            ack  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            run_op(kind != 3, kind == 0, kind == 1, sz, 1'($urandom), 1'($urandom), 1'($urandom),
                   a, $urandom, 5'($urandom), ack, $urandom, 1'($urandom));
        end

        // Reset while the bus request is outstanding.
        valid_em = 1; memread_em = 1; memsize_em = 2'b10; aluout_em = 32'h0000_0500;
        regwrite_em = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midreq_req_before", {31'h0, bus.req}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midreq_req_after", {31'h0, bus.req}, 32'h0);
        check_eq("midreq_stall", {31'h0, stall_mem}, 32'h0);
        check_eq("midreq_bus_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(1, 1, 0, 2'b10, 0, 1, 1, 32'h0000_0600, 32'h0, 3, 1, 32'h1357_9BDF, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
